iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring divider for the RISC-V M-extension ops DIV, DIVU, REM and REMU.
- Sits beside the execute-stage adder. The adder adds; this block repeatedly subtracts.
- Each trial subtraction runs on a Kogge_Stone_Adder instance: carry_in=1, input_B=~divisor.
- Start/busy/done handshake toward the execution unit, one result per operation.

Parameters:
- XLEN, 32: operand width. Only 32 is supported.
- ITERATIONS, XLEN: number of quotient-bit steps.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request. Sampled only while the block is accepting (IDLE or DONE).
- operation, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Captured with start.
- dividend, input, 32: captured with start.
- divisor, input, 32: captured with start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse; result is valid in that cycle.
- result, output, 32: quotient or remainder. Held until the next accepted start.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, result=0. All internal registers clear.
- States:
  - IDLE: start=1 captures the operands and goes to ITER.
  - ITER: 32 cycles, counter counts 0 to 31, then goes to FIX.
  - FIX: 1 cycle, writes result, goes to DONE.
  - DONE: 1 cycle. start=1 behaves as in IDLE; otherwise goes to IDLE.
- busy=1 exactly in ITER and FIX. done=1 exactly in DONE.
- Latency: done is high in the cycle after the 34th rising edge counting from the edge that sampled start. Back-to-back issue: start held high during DONE gives one result every 34 cycles.
- start in ITER or FIX is ignored, with no effect on the operation in flight.
- Capture, signed ops (DIV, REM): store |dividend| and |divisor|. Latch neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend). Unsigned ops store raw values with neg_q=neg_r=0.
- Each ITER cycle:
  - Form the 33-bit partial remainder: {rem, next dividend MSB}.
  - trial = low 32 bits minus divisor, computed on the adder.
  - Accept when carry_out=1 or bit 32 of the partial remainder=1. On accept, rem=trial and the quotient bit is 1; otherwise rem is the shifted value and the quotient bit is 0.
- FIX: apply two's-complement negation to the quotient when neg_q, and to the remainder when neg_r. Then select per operation.
- Divide by zero, all ops: quotient=0xFFFFFFFF, remainder=dividend. The iterations still run (same 34-cycle latency); FIX overrides the result.
- Signed overflow, DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. Same latency.
- Any |value| of 0x80000000 is handled as the unsigned 2^31 with no loss.

Optional Feature:
- Macro: DIVIDER_EARLY_OUT_EN.
- Defined: a capture that detects divide-by-zero, signed overflow, or |divisor| > |dividend| skips ITER and goes directly to FIX. done then rises 2 edges after the start edge.
  - For |divisor| > |dividend|: quotient=0 and remainder=dividend, with the original sign.
- Undefined: every operation takes exactly 34 cycles, with identical results.

Decomposition:
- Shared package holds:
  - operation encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - the state enum (IDLE, ITER, FIX, DONE);
  - XLEN.
- Trial subtraction reuses the existing Kogge_Stone_Adder as a single instance.
- No new sub-module. The FSM, counter and datapath live in iterative_divider.

Test Plan:
- DIVU 100/7 and REMU 100/7: done after 34 cycles; results 14 and 2. busy=1 for 33 cycles before done.
- DIV 0xFFFFFF9C (-100) / 7 gives 0xFFFFFFF2 (-14). REM of the same operands gives 0xFFFFFFFE (-2). REM -100 / -7 gives 0xFFFFFFFE.
- Divide by zero:
  - DIVU 0x1234 / 0 gives 0xFFFFFFFF.
  - REM 0x1234 / 0 gives 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- Handshake:
  - start pulsed again at cycle 10 of ITER is ignored: exactly one done, result unchanged.
  - start held high through DONE issues a second op; its done arrives 34 cycles later.
- reset asserted mid-ITER at cycle 15: busy, done and result go to 0 immediately. The next DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
- With DIVIDER_EARLY_OUT_EN: DIVU 5/9 gives done 2 cycles after start with result 0; REMU 5/9 gives 5. Without the macro, both take 34 cycles.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the radix-2 restoring divider: operation codes,
// controller states and the datapath width.
package iterative_divider_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to the unsigned value 2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/Kogge_Stone_Adder.sv
// Parallel-prefix (Kogge-Stone) adder with carry in/out, shared with the
// execute-stage adder and reused here for the trial subtraction.
module Kogge_Stone_Adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] g [LEVELS+1];
  logic [WIDTH-1:0] p [LEVELS+1];
  logic [WIDTH:0]   c;

  assign g[0] = input_A & input_B;
  assign p[0] = input_A ^ input_B;

  // Each level doubles the span of every group (generate, propagate) pair.
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_merge
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  assign c         = {g[LEVELS] | (p[LEVELS] & {WIDTH{carry_in}}), carry_in};
  assign sum       = p[0] ^ c[WIDTH-1:0];
  assign carry_out = c[WIDTH];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with start/busy/done.
// Optional DIVIDER_EARLY_OUT_EN skips the iterations for trivial operands.
module iterative_divider #(
  parameter int XLEN       = 32,
  parameter int ITERATIONS = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      operation,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state
);
  import iterative_divider_pkg::*;

  localparam int            CW   = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  // Handshake: start is sampled only in IDLE or DONE; busy covers ITER and
  // FIX; done is a single-cycle pulse with result valid in that cycle, and
  // result holds until the next accepted start.

  state_t          cur, nxt;
  logic [CW-1:0]   count;
  logic [1:0]      op_r;
  logic [XLEN-1:0] dvd_r, dvs_r, rem_r, quo_r, orig_r;
  logic            neg_q, neg_r, div_zero, ovf;

  logic            signed_op, zero_in, ovf_in, early, take;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] trial, q_fix, r_fix, fix_result;
  logic            carry, acc;

  assign signed_op = (operation == OP_DIV) || (operation == OP_REM);
  assign dvd_mag   = signed_op ? abs_val(dividend) : dividend;
  assign dvs_mag   = signed_op ? abs_val(divisor)  : divisor;
  assign zero_in   = (divisor == '0);
  assign ovf_in    = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

`ifdef DIVIDER_EARLY_OUT_EN
  assign early = zero_in || ovf_in || (dvs_mag > dvd_mag);
`else
  assign early = 1'b0;
`endif

  assign take = start && ((cur == IDLE) || (cur == DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt  = cur;
    busy = 1'b0;
    done = 1'b0;
    case (cur)
      IDLE: if (start) nxt = early ? FIX : ITER;
      ITER: begin
        busy = 1'b1;
        if (count == LAST) nxt = FIX;
      end
      FIX: begin
        busy = 1'b1;
        nxt  = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = start ? (early ? FIX : ITER) : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign state = cur;

  // Trial subtraction: partial - divisor as partial + ~divisor + 1.
  assign partial = {rem_r, dvd_r[XLEN-1]};

  Kogge_Stone_Adder #(.WIDTH(XLEN)) u_trial (
    .input_A   (partial[XLEN-1:0]),
    .input_B   (~dvs_r),
    .carry_in  (1'b1),
    .sum       (trial),
    .carry_out (carry)
  );

  // Bit 32 set means the partial remainder already exceeds any 32-bit divisor.
  assign acc = carry || partial[XLEN];

  always_comb begin
    q_fix = neg_q ? (~quo_r + 1'b1) : quo_r;
    r_fix = neg_r ? (~rem_r + 1'b1) : rem_r;
    if (div_zero) begin
      q_fix = '1;
      r_fix = orig_r;
    end else if (ovf) begin
      q_fix = {1'b1, {(XLEN-1){1'b0}}};
      r_fix = '0;
    end
    fix_result = ((op_r == OP_REM) || (op_r == OP_REMU)) ? r_fix : q_fix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      op_r     <= '0;
      dvd_r    <= '0;
      dvs_r    <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      orig_r   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      result   <= '0;
    end else begin
      if (take) begin
        count    <= '0;
        op_r     <= operation;
        dvd_r    <= dvd_mag;
        dvs_r    <= dvs_mag;
        // An early-out with a larger divisor leaves the dividend as remainder.
        rem_r    <= early ? dvd_mag : '0;
        quo_r    <= '0;
        orig_r   <= dividend;
        neg_q    <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        neg_r    <= signed_op && dividend[XLEN-1];
        div_zero <= zero_in;
        ovf      <= ovf_in;
      end else if (cur == ITER) begin
        rem_r <= acc ? trial : partial[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], acc};
        dvd_r <= dvd_r << 1;
        count <= count + 1'b1;
      end
      if (cur == FIX) result <= fix_result;
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed corner cases,
// handshake scenarios and randomized operations against an arithmetic model.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  operation;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  iterative_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf_case;
    ovf_case = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf_case) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      default: begin
        if (b == 0) return a;
        if (ovf_case) return 32'h0;
        return $signed(a) % $signed(b);
      end
    endcase
  endfunction

  // Edges from the start-sampling edge (inclusive) to the edge entering DONE.
  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic   sgn;
    longint ma, mb;
    logic   trivial;
    sgn = (op == OP_DIV) || (op == OP_REM);
    ma  = sgn ? longint'($signed(a)) : longint'(a);
    mb  = sgn ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    trivial = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (mb > ma);
`ifdef DIVIDER_EARLY_OUT_EN
    return trivial ? 2 : 34;
`else
    return (trivial === 1'bx) ? 0 : 34;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit hold, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!hold && lat == 1) start = 1'b0;
      if (busy) busy_cnt++;
    end while (!done && lat < 100);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    int lat, busy_cnt, exp_lat;
    logic [31:0] exp;
    @(negedge clk);
    operation = op;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    exp_q.push_back(model(op, a, b));
    exp_lat = model_lat(op, a, b);
    wait_done(hold, lat, busy_cnt);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    if (!hold) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_result_held"}, result, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    logic [31:0] seen;
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1;
    start = 1'b0;
    operation = '0;
    dividend = '0;
    divisor = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 1'b0);
    run_op("div_m100_7", OP_DIV,  32'hFFFF_FF9C, 32'd7, 1'b0);
    run_op("rem_m100_7", OP_REM,  32'hFFFF_FF9C, 32'd7, 1'b0);
    run_op("rem_m100_m7", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    run_op("divu_by_zero", OP_DIVU, 32'h1234, 32'h0, 1'b0);
    run_op("rem_by_zero", OP_REM, 32'h1234, 32'h0, 1'b0);
    run_op("div_by_zero_neg", OP_DIV, 32'h8000_0001, 32'h0, 1'b0);
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_min_by_1", OP_DIVU, 32'h8000_0000, 32'd1, 1'b0);
    run_op("div_min_by_2", OP_DIV, 32'h8000_0000, 32'd2, 1'b0);
    run_op("divu_5_9", OP_DIVU, 32'd5, 32'd9, 1'b0);
    run_op("remu_5_9", OP_REMU, 32'd5, 32'd9, 1'b0);
    run_op("rem_m5_9", OP_REM, 32'hFFFF_FFFB, 32'd9, 1'b0);

    // start pulsed during ITER must be ignored
    @(negedge clk);
    operation = OP_DIVU;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    operation = OP_REMU;
    dividend  = 32'd77;
    divisor   = 32'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    seen  = '0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        seen = result;
      end
    end
    check("ignore_start_done_count", 32'(dones), 32'd1);
    check("ignore_start_result", seen, 32'd100);

    // back-to-back issue with start held through DONE
    run_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 1'b1);
    run_op("b2b_second", OP_REMU, 32'd200, 32'd9, 1'b0);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    operation = OP_DIVU;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    check("mid_reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset_divu", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // randomized operations
    for (int i = 0; i < 50; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = $urandom_range(1, 20);
        2: b = 32'h0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = $urandom_range(0, 1000); b = $urandom_range(1001, 5000); end
        default: begin
          a = -32'($urandom_range(1, 5000));
          b = $urandom_range(0, 1) ? 32'($urandom_range(1, 40)) : -32'($urandom_range(1, 40));
        end
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, 1'b0);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
